// File: rtl/ysyx_23060229_ifu_if.sv
// AXI4-Lite-style read channel between the instruction fetch unit (master)
// and instruction memory (slave).
interface ysyx_23060229_ifu_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/ysyx_23060229_ifu.sv
// Instruction fetch unit: one outstanding read per accepted PC, result handed
// to decode over valid/ready; misaligned PCs and bus errors are flagged.
module ysyx_23060229_ifu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic                  i_pc_valid,
    input  logic                  i_flush,
    output logic                  o_busy,
    ysyx_23060229_ifu_if.master   bus,
    output logic [DATA_WIDTH-1:0] o_inst,
    output logic [ADDR_WIDTH-1:0] o_inst_pc,
    output logic                  o_inst_err,
    output logic                  o_inst_valid,
    input  logic                  i_inst_ready,
    output logic [CNT_WIDTH-1:0]  o_fetch_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_OUT} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic                  r_arvalid;
    logic                  r_rready;
    logic [DATA_WIDTH-1:0] r_inst;
    logic                  r_err;
    logic                  r_inst_valid;
    logic                  r_flush_pending;
    logic [CNT_WIDTH-1:0]  r_fetch_cnt;

    logic w_misaligned;
    logic w_discard;

    assign w_misaligned = (i_pc[1:0] != 2'b00);
    // A redirect seen at any point during the bus transaction kills its result.
    assign w_discard    = r_flush_pending | i_flush;

    assign o_busy       = (r_state != S_IDLE);
    assign bus.araddr   = r_araddr;
    assign bus.arvalid  = r_arvalid;
    assign bus.rready   = r_rready;
    assign o_inst       = r_inst;
    assign o_inst_pc    = r_pc;
    assign o_inst_err   = r_err;
    assign o_inst_valid = r_inst_valid;
    assign o_fetch_cnt  = r_fetch_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_pc            <= '0;
            r_araddr        <= '0;
            r_arvalid       <= 1'b0;
            r_rready        <= 1'b0;
            r_inst          <= '0;
            r_err           <= 1'b0;
            r_inst_valid    <= 1'b0;
            r_flush_pending <= 1'b0;
            r_fetch_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_flush_pending <= 1'b0;
                    if (i_pc_valid) begin
                        r_pc <= i_pc;
                        if (w_misaligned) begin
                            r_inst       <= '0;
                            r_err        <= 1'b1;
                            r_inst_valid <= 1'b1;
                            r_state      <= S_OUT;
                        end else begin
                            r_araddr  <= i_pc;
                            r_arvalid <= 1'b1;
                            r_state   <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    // The address phase always completes, even under flush.
                    if (i_flush) begin
                        r_flush_pending <= 1'b1;
                    end
                    if (bus.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_R;
                    end
                end
                S_R: begin
                    if (i_flush) begin
                        r_flush_pending <= 1'b1;
                    end
                    if (bus.rvalid) begin
                        r_rready <= 1'b0;
                        r_inst   <= bus.rdata;
                        r_err    <= |bus.rresp;
                        if (w_discard) begin
                            r_flush_pending <= 1'b0;
                            r_state         <= S_IDLE;
                        end else begin
                            r_inst_valid <= 1'b1;
                            r_state      <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (i_flush) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end else if (i_inst_ready) begin
                        r_inst_valid <= 1'b0;
                        r_fetch_cnt  <= r_fetch_cnt + CNT_WIDTH'(1);
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_23060229_ifu.sv
// Bench for ysyx_23060229_ifu: transaction-level reference model checked every
// cycle, a configurable-latency memory, and directed scenarios with literal pins.
module tb_ysyx_23060229_ifu;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   i_pc;
    logic          i_pc_valid;
    logic          i_flush;
    logic          o_busy;
    logic [31:0]   o_inst;
    logic [31:0]   o_inst_pc;
    logic          o_inst_err;
    logic          o_inst_valid;
    logic          i_inst_ready;
    logic [CW-1:0] o_fetch_cnt;

    ysyx_23060229_ifu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    ysyx_23060229_ifu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_pc         (i_pc),
        .i_pc_valid   (i_pc_valid),
        .i_flush      (i_flush),
        .o_busy       (o_busy),
        .bus          (bus),
        .o_inst       (o_inst),
        .o_inst_pc    (o_inst_pc),
        .o_inst_err   (o_inst_err),
        .o_inst_valid (o_inst_valid),
        .i_inst_ready (i_inst_ready),
        .o_fetch_cnt  (o_fetch_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: arready after cfg_ar_delay cycles of arvalid, rvalid cfg_r_delay cycles after that.
    int          cfg_ar_delay = 0;
    int          cfg_r_delay  = 0;
    logic [31:0] cfg_data     = 32'h0;
    logic [1:0]  cfg_resp     = 2'b00;
    int          ar_cnt       = 0;
    int          r_cnt        = 0;
    bit          r_pending    = 1'b0;
    bit          ar_hs_next   = 1'b0;
    bit          r_hs_next    = 1'b0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.arready = 1'b0;
            bus.rvalid  = 1'b0;
            ar_cnt      = 0;
            r_cnt       = 0;
            r_pending   = 1'b0;
            ar_hs_next  = 1'b0;
            r_hs_next   = 1'b0;
        end else begin
            if (ar_hs_next) begin
                r_pending = 1'b1;
                r_cnt     = 0;
            end
            if (r_hs_next) r_pending = 1'b0;
            bus.arready = 1'b0;
            bus.rvalid  = 1'b0;
            if (bus.arvalid && !r_pending) begin
                if (ar_cnt >= cfg_ar_delay) begin
                    bus.arready = 1'b1;
                    ar_cnt      = 0;
                end else ar_cnt++;
            end
            if (r_pending) begin
                if (r_cnt >= cfg_r_delay) begin
                    bus.rvalid = 1'b1;
                    bus.rdata  = cfg_data;
                    bus.rresp  = cfg_resp;
                end else r_cnt++;
            end
            ar_hs_next = bus.arvalid && bus.arready;
            r_hs_next  = bus.rvalid && bus.rready;
        end
    end

    // Reference model: a single fetch record and what it has achieved so far.
    logic          f_active, f_addr_done, f_data_done, f_discard, f_err;
    logic [31:0]   f_pc, f_inst;
    logic [CW-1:0] m_cnt;
    logic          e_arvalid, e_rready, e_valid;

    assign e_arvalid = f_active & ~f_addr_done;
    assign e_rready  = f_active & f_addr_done & ~f_data_done;
    assign e_valid   = f_active & f_data_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_active <= 1'b0; f_addr_done <= 1'b0; f_data_done <= 1'b0;
            f_discard <= 1'b0; f_err <= 1'b0; f_pc <= 32'h0; f_inst <= 32'h0;
            m_cnt <= '0;
        end else if (!f_active) begin
            if (i_pc_valid) begin
                f_active  <= 1'b1;
                f_pc      <= i_pc;
                f_discard <= 1'b0;
                if (i_pc % 4 != 0) begin
                    f_addr_done <= 1'b1; f_data_done <= 1'b1; f_inst <= 32'h0; f_err <= 1'b1;
                end else begin
                    f_addr_done <= 1'b0; f_data_done <= 1'b0;
                end
            end
        end else if (!f_addr_done) begin
            if (i_flush) f_discard <= 1'b1;
            if (bus.arready) f_addr_done <= 1'b1;
        end else if (!f_data_done) begin
            if (i_flush) f_discard <= 1'b1;
            if (bus.rvalid) begin
                f_inst <= bus.rdata;
                f_err  <= (bus.rresp != 2'b00);
                if (f_discard || i_flush) f_active <= 1'b0;
                else f_data_done <= 1'b1;
            end
        end else begin
            if (i_flush) f_active <= 1'b0;
            else if (i_inst_ready) begin
                f_active <= 1'b0;
                m_cnt    <= m_cnt + 1'b1;
            end
        end
    end

    bit chk_on = 1'b0;
    always @(negedge clk) begin
        if (chk_on) begin
            check("busy", o_busy, f_active);
            check("arvalid", bus.arvalid, e_arvalid);
            check("rready", bus.rready, e_rready);
            check("inst_valid", o_inst_valid, e_valid);
            check("fetch_cnt", o_fetch_cnt, m_cnt);
            if (e_arvalid) check("araddr", bus.araddr, f_pc);
            if (e_valid) begin
                check("inst", o_inst, f_inst);
                check("inst_pc", o_inst_pc, f_pc);
                check("inst_err", o_inst_err, f_err);
            end
        end
    end

    task automatic fetch(input logic [31:0] pc, output int lat);
        i_pc = pc;
        i_pc_valid = 1'b1;
        @(negedge clk);
        i_pc_valid = 1'b0;
        lat = 1;
        while (!o_inst_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("inst_valid_seen", o_inst_valid, 1);
        $display("fetch pc=0x%08h inst=0x%08h err=%0d latency=%0d", pc, o_inst, o_inst_err, lat);
    endtask

    task automatic take();
        i_inst_ready = 1'b1;
        @(negedge clk);
        i_inst_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int lat;

    initial begin
        rst_n = 1'b0; i_pc = 32'h0; i_pc_valid = 1'b0; i_flush = 1'b0; i_inst_ready = 1'b0;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.rresp = 2'b00;
        repeat (2) @(negedge clk);
        check("rst_busy", o_busy, 0);
        check("rst_arvalid", bus.arvalid, 0);
        check("rst_inst_valid", o_inst_valid, 0);
        check("rst_inst_pc", o_inst_pc, 0);
        check("rst_cnt", o_fetch_cnt, 0);
        rst_n = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);

        // Zero-wait fetch with cycle-exact pins
        cfg_data = 32'h0000_0413;
        i_pc = 32'h8000_0000; i_pc_valid = 1'b1;
        @(negedge clk);
        i_pc_valid = 1'b0;
        check("t1_arvalid_c1", bus.arvalid, 1);
        check("t1_araddr_c1", bus.araddr, 32'h8000_0000);
        @(negedge clk);
        check("t1_rready_c2", bus.rready, 1);
        check("t1_no_valid_c2", o_inst_valid, 0);
        @(negedge clk);
        check("t1_valid_c3", o_inst_valid, 1);
        check("t1_inst", o_inst, 32'h0000_0413);
        check("t1_inst_pc", o_inst_pc, 32'h8000_0000);
        check("t1_err", o_inst_err, 0);
        $display("fetch pc=0x80000000 inst=0x%08h latency=3", o_inst);
        take();
        check("t1_cnt", o_fetch_cnt, 1);

        // Slow memory: arready after 3 cycles, rvalid 2 cycles after address
        cfg_ar_delay = 3; cfg_r_delay = 2; cfg_data = 32'h00a0_0093;
        fetch(32'h8000_0004, lat);
        check("t2_latency", lat, 8);
        check("t2_inst", o_inst, 32'h00a0_0093);
        take();
        cfg_ar_delay = 0; cfg_r_delay = 0;

        // Misaligned PC, then a bus error on an aligned PC
        fetch(32'h8000_0002, lat);
        check("t3_mis_latency", lat, 1);
        check("t3_mis_err", o_inst_err, 1);
        check("t3_mis_inst", o_inst, 0);
        take();
        cfg_resp = 2'b10; cfg_data = 32'hdead_beef;
        fetch(32'h8000_0008, lat);
        check("t3_berr_err", o_inst_err, 1);
        check("t3_berr_inst", o_inst, 32'hdead_beef);
        take();
        cfg_resp = 2'b00;
        check("t3_cnt", o_fetch_cnt, 4);

        // Flush while the address is still waiting for arready
        cfg_ar_delay = 3;
        i_pc = 32'h8000_0010; i_pc_valid = 1'b1;
        @(negedge clk);
        i_pc_valid = 1'b0; i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        for (int k = 0; k < 30 && o_busy; k++) @(negedge clk);
        check("t4_idle_after_flush", o_busy, 0);
        check("t4_cnt_kept", o_fetch_cnt, 4);
        $display("fetch pc=0x80000010 flushed in address phase");
        cfg_ar_delay = 0;

        // Flush and inst_ready together in OUT: flush wins
        cfg_data = 32'h0000_0067;
        fetch(32'h8000_0014, lat);
        i_flush = 1'b1; i_inst_ready = 1'b1;
        @(negedge clk);
        i_flush = 1'b0; i_inst_ready = 1'b0;
        check("t4_out_flush_valid", o_inst_valid, 0);
        check("t4_out_flush_cnt", o_fetch_cnt, 4);

        // Decode stalls 5 cycles while upstream pulses pc_valid
        cfg_data = 32'h0000_0013;
        fetch(32'h8000_0020, lat);
        for (int k = 0; k < 5; k++) begin
            i_pc = 32'h8000_0100 + 32'(k * 4);
            i_pc_valid = k[0];
            @(negedge clk);
            check("t5_hold_valid", o_inst_valid, 1);
            check("t5_hold_inst", o_inst, 32'h0000_0013);
            check("t5_hold_pc", o_inst_pc, 32'h8000_0020);
        end
        i_pc_valid = 1'b0;
        take();
        check("t5_cnt", o_fetch_cnt, 5);

        // Asynchronous reset while waiting for read data
        cfg_r_delay = 4;
        i_pc = 32'h8000_0030; i_pc_valid = 1'b1;
        @(negedge clk);
        i_pc_valid = 1'b0;
        for (int k = 0; k < 10 && !bus.rready; k++) @(negedge clk);
        check("t5_in_r", bus.rready, 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_busy", o_busy, 0);
        check("ar_arvalid", bus.arvalid, 0);
        check("ar_rready", bus.rready, 0);
        check("ar_araddr", bus.araddr, 0);
        check("ar_inst_valid", o_inst_valid, 0);
        check("ar_inst_err", o_inst_err, 0);
        check("ar_inst", o_inst, 0);
        check("ar_inst_pc", o_inst_pc, 0);
        check("ar_cnt", o_fetch_cnt, 0);
        $display("fetch pc=0x80000030 abandoned by reset");
        @(negedge clk);
        rst_n = 1'b1;
        cfg_r_delay = 0;
        @(negedge clk);

        // Counter wrap with a 4-bit counter
        for (int i = 0; i < 16; i++) begin
            cfg_data = 32'h0010_0093 + 32'(i << 7);
            fetch(32'h8000_1000 + 32'(i * 4), lat);
            check("t6_inst", o_inst, cfg_data);
            take();
            if (i == 14) check("t6_cnt_15", o_fetch_cnt, 15);
        end
        check("t6_cnt_wrap", o_fetch_cnt, 0);

        @(negedge clk);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
